lcplc_stream_framer: RTL and testbench

- Generates the four hierarchical last flags (row, band, slice, image) for the LCPLC sample stream from configured dimensions. This replaces per-flag side files and external flag generation.
- Sits between any raw AXI-stream sample source and the LCPLC coder input.
- Parametrised in sample width, dimension widths and lane count.
- Adds per-frame configuration, a registered full-throughput output and protocol-error reporting.

---
 rtl/lcplc_stream_pkg.sv | 39 +++
 rtl/axis_skid_buffer.sv | 61 ++++++
 rtl/lcplc_stream_framer.sv | 127 ++++++++++++
 tb/tb_lcplc_stream_framer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcplc_stream_pkg.sv
// rtl/lcplc_stream_pkg.sv - shared types for the LCPLC stream framer
package lcplc_stream_pkg;

  // Widest supported dimension field; narrower config fields are zero-extended into it.
  localparam int DIM_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic last_i;
    logic last_s;
    logic last_b;
    logic last_r;
  } flags_t;

  localparam int FLAGS_W = $bits(flags_t);

  typedef struct packed {
    logic [DIM_MAX_W-1:0] cols;
    logic [DIM_MAX_W-1:0] rows;
    logic [DIM_MAX_W-1:0] bands;
    logic [DIM_MAX_W-1:0] slices;
  } frame_cfg_t;

  // Each flag also requires every finer level to be at its end, so flags nest.
  function automatic flags_t calc_flags(input frame_cfg_t cnt, input frame_cfg_t cfg);
    flags_t f;
    f.last_r = (cnt.cols == cfg.cols);
    f.last_b = f.last_r & (cnt.rows == cfg.rows);
    f.last_s = f.last_b & (cnt.bands == cfg.bands);
    f.last_i = f.last_s & (cnt.slices == cfg.slices);
    return f;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered skid buffer, full throughput
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             push;

  // Ready comes only from the skid register, so there is no path from m_tready.
  assign s_tready = ~skid_valid_q;
  assign push     = s_tvalid & ~skid_valid_q;
  assign m_tdata  = out_data_q;
  assign m_tvalid = out_valid_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_tready) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_data_d = s_tdata;
      end
    end else if (push) begin
      skid_data_d  = s_tdata;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/lcplc_stream_framer.sv
// rtl/lcplc_stream_framer.sv - adds row/band/slice/image last flags to a sample stream
module lcplc_stream_framer
  import lcplc_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 1,
  parameter int COL_WIDTH   = 8,
  parameter int ROW_WIDTH   = 8,
  parameter int BAND_WIDTH  = 8,
  parameter int SLICE_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [COL_WIDTH-1:0]        cfg_cols,
  input  logic [ROW_WIDTH-1:0]        cfg_rows,
  input  logic [BAND_WIDTH-1:0]       cfg_bands,
  input  logic [SLICE_WIDTH-1:0]      cfg_slices,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic [LANES*DATA_WIDTH-1:0] x_data,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic [LANES*DATA_WIDTH-1:0] y_data,
  output logic                        y_last_r,
  output logic                        y_last_b,
  output logic                        y_last_s,
  output logic                        y_last_i,
  output logic                        busy,
  output logic                        err_early_cfg
);

  localparam int DW = LANES * DATA_WIDTH;
  localparam int PW = FLAGS_W + DW;

  state_e     state_q, state_d;
  frame_cfg_t cfg_q, cfg_d;
  frame_cfg_t cnt_q, cnt_d;
  logic       cfg_ready_q;
  logic       err_q;
  flags_t     flags;
  flags_t     y_flags;
  logic       skid_ready;
  logic       accept;
  logic       cfg_take;
  logic [PW-1:0] skid_in;
  logic [PW-1:0] skid_out;

  assign flags    = calc_flags(cnt_q, cfg_q);
  assign x_ready  = (state_q == RUN) & skid_ready;
  assign accept   = x_valid & x_ready;
  assign cfg_take = cfg_valid & cfg_ready_q;
  assign skid_in  = {flags, x_data};

  assign cfg_ready     = cfg_ready_q;
  assign busy          = (state_q != IDLE);
  assign err_early_cfg = err_q;
  assign y_flags       = flags_t'(skid_out[PW-1:DW]);
  assign y_data        = skid_out[DW-1:0];
  assign y_last_r      = y_flags.last_r;
  assign y_last_b      = y_flags.last_b;
  assign y_last_s      = y_flags.last_s;
  assign y_last_i      = y_flags.last_i;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cfg_take) begin
          cfg_d.cols   = DIM_MAX_W'(cfg_cols);
          cfg_d.rows   = DIM_MAX_W'(cfg_rows);
          cfg_d.bands  = DIM_MAX_W'(cfg_bands);
          cfg_d.slices = DIM_MAX_W'(cfg_slices);
          cnt_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        // A counter only advances while below its cfg value, so it cannot overflow.
        if (accept) begin
          cnt_d.cols = flags.last_r ? '0 : cnt_q.cols + DIM_MAX_W'(1);
          if (flags.last_r) cnt_d.rows   = flags.last_b ? '0 : cnt_q.rows + DIM_MAX_W'(1);
          if (flags.last_b) cnt_d.bands  = flags.last_s ? '0 : cnt_q.bands + DIM_MAX_W'(1);
          if (flags.last_s) cnt_d.slices = flags.last_i ? '0 : cnt_q.slices + DIM_MAX_W'(1);
          if (flags.last_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (y_valid && y_ready && y_flags.last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      cfg_ready_q <= (state_d == IDLE);
      err_q       <= cfg_valid & (state_q != IDLE);
    end
  end

  axis_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst),
    .s_tdata  (skid_in),
    .s_tvalid (accept),
    .s_tready (skid_ready),
    .m_tdata  (skid_out),
    .m_tvalid (y_valid),
    .m_tready (y_ready)
  );

endmodule

// File: tb/tb_lcplc_stream_framer.sv
// tb/tb_lcplc_stream_framer.sv - scoreboard bench for lcplc_stream_framer
module tb_lcplc_stream_framer;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int W  = DW * LN;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [7:0]    cfg_cols = '0;
  logic [7:0]    cfg_rows = '0;
  logic [7:0]    cfg_bands = '0;
  logic [11:0]   cfg_slices = '0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [W-1:0]  x_data = '0;
  logic          y_valid;
  logic          y_ready = 1'b1;
  logic [W-1:0]  y_data;
  logic          y_last_r, y_last_b, y_last_s, y_last_i;
  logic          busy;
  logic          err_early_cfg;

  always #5 clk = ~clk;

  lcplc_stream_framer #(
    .DATA_WIDTH(DW), .LANES(LN), .COL_WIDTH(8), .ROW_WIDTH(8),
    .BAND_WIDTH(8), .SLICE_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_bands(cfg_bands), .cfg_slices(cfg_slices),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_last_r(y_last_r), .y_last_b(y_last_b), .y_last_s(y_last_s), .y_last_i(y_last_i),
    .busy(busy), .err_early_cfg(err_early_cfg)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   flags;
    int           cyc;
    int           idx;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cycle = 0;
  int           err_pulses = 0;
  int           sink_mode = 0;
  logic         held_v = 1'b0;
  logic [W-1:0] held_data = '0;
  logic [3:0]   held_flags = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected flags from the beat's position in the frame: beat n (1-based) ends a row
  // when n is a multiple of the row size, and so on up the hierarchy.
  function automatic logic [3:0] ref_flags(input int k, input int c, input int r, input int b, input int s);
    int n;
    n = k + 1;
    return {n == c * r * b * s, (n % (c * r * b)) == 0, (n % (c * r)) == 0, (n % c) == 0};
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #1;
    case (sink_mode)
      0: y_ready = 1'b1;
      1: y_ready = ~y_ready;
      2: y_ready = 1'($urandom_range(0, 1));
      default: y_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      held_v <= 1'b0;
    end else begin
      if (err_early_cfg) err_pulses <= err_pulses + 1;
      if (held_v && y_valid) begin
        check("hold_data", y_data, held_data);
        check("hold_flags", {y_last_i, y_last_s, y_last_b, y_last_r}, held_flags);
      end
      held_v     <= y_valid && !y_ready;
      held_data  <= y_data;
      held_flags <= {y_last_i, y_last_s, y_last_b, y_last_r};
      if (y_valid && y_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'(y_data), 64'hdead);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("data_beat%0d", mon_e.idx), y_data, mon_e.data);
          check($sformatf("flags_beat%0d", mon_e.idx), {y_last_i, y_last_s, y_last_b, y_last_r}, mon_e.flags);
          if (sink_mode == 0) check($sformatf("latency_beat%0d", mon_e.idx), 64'(cycle - mon_e.cyc), 64'd1);
        end
      end
    end
  end

  task automatic configure(input int c, input int r, input int b, input int s);
    int n;
    cfg_cols   = 8'(c - 1);
    cfg_rows   = 8'(r - 1);
    cfg_bands  = 8'(b - 1);
    cfg_slices = 12'(s - 1);
    cfg_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cfg_accept", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic run_frame(input int c, input int r, input int b, input int s, input int mode,
                           input int vpct, input int poke, output int first_acc, output int last_acc);
    int   total, k, guard, pulses0, n;
    bit   poked;
    total = c * r * b * s;
    k = 0; guard = 0; poked = 0; first_acc = 0; last_acc = 0;
    sink_mode = mode;
    pulses0 = err_pulses;
    configure(c, r, b, s);
    while (k < total && guard < 20000) begin
      x_valid = ($urandom_range(0, 99) < vpct);
      x_data  = {$urandom, $urandom};
      cfg_valid = 1'b0;
      if (!poked && k == poke) begin
        poked      = 1;
        cfg_valid  = 1'b1;
        cfg_cols   = 8'($urandom);
        cfg_rows   = 8'($urandom);
        cfg_bands  = 8'($urandom);
        cfg_slices = 12'($urandom);
      end
      @(negedge clk);
      if (x_valid && x_ready) begin
        sb.push_back('{data: x_data, flags: ref_flags(k, c, r, b, s), cyc: cycle, idx: k});
        if (k == 0) first_acc = cycle;
        last_acc = cycle;
        k++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    x_valid = 1'b0;
    cfg_valid = 1'b0;
    check("beats_accepted", 64'(k), 64'(total));
    @(negedge clk);
    check("x_ready_after_last", 64'(x_ready), 64'd0);
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("busy_falls", 64'(busy), 64'd0);
    check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("err_pulse_count", 64'(err_pulses - pulses0), 64'(poke >= 0 ? 1 : 0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa, la, nacc;
    #2;
    check("rst_y_valid", 64'(y_valid), 64'd0);
    check("rst_y_data", 64'(y_data), 64'd0);
    check("rst_flags", 64'({y_last_i, y_last_s, y_last_b, y_last_r}), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_x_ready", 64'(x_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_early_cfg), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_cfg_ready", 64'(cfg_ready), 64'd1);

    run_frame(4, 2, 1, 1, 0, 100, -1, fa, la);
    run_frame(2, 2, 2, 2, 1, 60, -1, fa, la);
    run_frame(1, 1, 1, 1, 0, 100, -1, fa, la);
    run_frame(1, 1, 1, 1, 2, 100, -1, fa, la);
    run_frame(3, 2, 2, 1, 2, 70, 3, fa, la);

    // Reset with both buffer entries occupied and the sink stalled.
    sink_mode = 3;
    @(posedge clk);
    #1;
    configure(2, 2, 2, 2);
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      x_valid = 1'b1;
      x_data  = {$urandom, $urandom};
      @(negedge clk);
      if (x_valid && x_ready) nacc++;
      @(posedge clk);
      #1;
    end
    x_valid = 1'b0;
    check("buffered_beats", 64'(nacc), 64'd2);
    @(negedge clk);
    check("pre_rst_y_valid", 64'(y_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_y_valid", 64'(y_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_x_ready", 64'(x_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_frame(4, 2, 1, 1, 0, 100, -1, fa, la);

    run_frame(256, 2, 1, 1, 0, 100, -1, fa, la);
    check("throughput_cycles", 64'(la - fa), 64'd511);

    for (int t = 0; t < 3; t++) begin
      run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 2)), 2, 75, -1, fa, la);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
